// File: rtl/eprisc_bus_arbiter.sv
// Round-robin owner of the 8-bit parallel IO bus, shared by the core (A) and the DMA (B).
// Optional: define EPRISC_BUS_IRQ_PRIORITY_EN so a pending interrupt lets requester A win.
module eprisc_bus_arbiter #(
    parameter int unsigned CLKDIV = 2,
    parameter int unsigned GAP    = 1
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iReqA,
    input  logic [1:0] iSelA,
    input  logic [7:0] iLenA,
    input  logic [7:0] iTxDataA,
    output logic       oGntA,
    output logic       oTxTakeA,
    output logic [7:0] oRxDataA,
    output logic       oRxValidA,
    output logic       oDoneA,
    input  logic       iReqB,
    input  logic [1:0] iSelB,
    input  logic [7:0] iLenB,
    input  logic [7:0] iTxDataB,
    output logic       oGntB,
    output logic       oTxTakeB,
    output logic [7:0] oRxDataB,
    output logic       oRxValidB,
    output logic       oDoneB,
    output logic       oBusClock,
    output logic [1:0] oBusSelect,
    output logic [7:0] oBusMOSI,
    input  logic [7:0] iBusMISO,
    input  logic       iBusInterrupt
);
    typedef enum logic [2:0] {StIdle, StLoad, StLow, StHigh, StGap} state_t;

    localparam logic [15:0] HalfLast = 16'(CLKDIV - 1);
    localparam logic [15:0] GapLast  = 16'(GAP - 1);

    state_t      state;
    logic [8:0]  count;
    logic [15:0] tick;
    logic        curB;
    logic        lastB;
    logic        pickB;
    logic [7:0]  txData;

    assign txData = curB ? iTxDataB : iTxDataA;

    // With both requesting, the one not served last wins.
    always_comb begin
        pickB = iReqB && !(iReqA && lastB);
`ifdef EPRISC_BUS_IRQ_PRIORITY_EN
        if (iBusInterrupt && iReqA) pickB = 1'b0;
`endif
    end

`ifndef EPRISC_BUS_IRQ_PRIORITY_EN
    logic unusedIrq;
    assign unusedIrq = iBusInterrupt;
`endif

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= StIdle;
            count      <= '0;
            tick       <= '0;
            curB       <= 1'b0;
            lastB      <= 1'b1;
            oGntA      <= 1'b0;
            oTxTakeA   <= 1'b0;
            oRxDataA   <= '0;
            oRxValidA  <= 1'b0;
            oDoneA     <= 1'b0;
            oGntB      <= 1'b0;
            oTxTakeB   <= 1'b0;
            oRxDataB   <= '0;
            oRxValidB  <= 1'b0;
            oDoneB     <= 1'b0;
            oBusClock  <= 1'b0;
            oBusSelect <= '0;
            oBusMOSI   <= '0;
        end else begin
            oTxTakeA  <= 1'b0;
            oTxTakeB  <= 1'b0;
            oRxValidA <= 1'b0;
            oRxValidB <= 1'b0;
            oDoneA    <= 1'b0;
            oDoneB    <= 1'b0;
            case (state)
                StIdle: begin
                    if (iReqA || iReqB) begin
                        state      <= StLoad;
                        curB       <= pickB;
                        count      <= pickB ? {iLenB == 8'd0, iLenB} : {iLenA == 8'd0, iLenA};
                        oGntA      <= !pickB;
                        oGntB      <= pickB;
                        oTxTakeA   <= !pickB;
                        oTxTakeB   <= pickB;
                        oBusSelect <= pickB ? iSelB : iSelA;
                        oBusMOSI   <= pickB ? iTxDataB : iTxDataA;
                    end
                end
                StLoad: begin
                    state <= StLow;
                    tick  <= '0;
                end
                StLow: begin
                    if (tick == HalfLast) begin
                        state     <= StHigh;
                        tick      <= '0;
                        oBusClock <= 1'b1;
                        if (curB) begin
                            oRxDataB  <= iBusMISO;
                            oRxValidB <= 1'b1;
                        end else begin
                            oRxDataA  <= iBusMISO;
                            oRxValidA <= 1'b1;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                StHigh: begin
                    if (tick == HalfLast) begin
                        tick      <= '0;
                        oBusClock <= 1'b0;
                        count     <= count - 9'd1;
                        if (count == 9'd1) begin
                            state      <= StGap;
                            oBusSelect <= '0;
                            oGntA      <= 1'b0;
                            oGntB      <= 1'b0;
                            oDoneA     <= !curB;
                            oDoneB     <= curB;
                            lastB      <= curB;
                        end else begin
                            state    <= StLoad;
                            oBusMOSI <= txData;
                            oTxTakeA <= !curB;
                            oTxTakeB <= curB;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                StGap: begin
                    if (tick == GapLast) begin
                        state <= StIdle;
                        tick  <= '0;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Bench for eprisc_bus_arbiter: arbitration vector table, directed bursts, and random traffic
// checked every cycle against a burst-position reference model.
module tb_eprisc_bus_arbiter;
    localparam int CLKDIV = 2;
    localparam int GAP    = 1;
    localparam int P      = 1 + 2 * CLKDIV;

    logic       iClock = 1'b0;
    logic       iReset = 1'b1;
    logic       iReqA = 1'b0, iReqB = 1'b0;
    logic [1:0] iSelA = '0, iSelB = '0;
    logic [7:0] iLenA = 8'd1, iLenB = 8'd1;
    logic [7:0] iTxDataA = '0, iTxDataB = '0;
    logic [7:0] iBusMISO = '0;
    logic       iBusInterrupt = 1'b0;
    logic       oGntA, oTxTakeA, oRxValidA, oDoneA;
    logic       oGntB, oTxTakeB, oRxValidB, oDoneB;
    logic [7:0] oRxDataA, oRxDataB, oBusMOSI;
    logic       oBusClock;
    logic [1:0] oBusSelect;

    eprisc_bus_arbiter #(.CLKDIV(CLKDIV), .GAP(GAP)) dut (
        .iClock(iClock), .iReset(iReset),
        .iReqA(iReqA), .iSelA(iSelA), .iLenA(iLenA), .iTxDataA(iTxDataA),
        .oGntA(oGntA), .oTxTakeA(oTxTakeA), .oRxDataA(oRxDataA), .oRxValidA(oRxValidA),
        .oDoneA(oDoneA),
        .iReqB(iReqB), .iSelB(iSelB), .iLenB(iLenB), .iTxDataB(iTxDataB),
        .oGntB(oGntB), .oTxTakeB(oTxTakeB), .oRxDataB(oRxDataB), .oRxValidB(oRxValidB),
        .oDoneB(oDoneB),
        .oBusClock(oBusClock), .oBusSelect(oBusSelect), .oBusMOSI(oBusMOSI),
        .iBusMISO(iBusMISO), .iBusInterrupt(iBusInterrupt)
    );

    always #5 iClock = ~iClock;

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nErrors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: tracks position within the current burst, counted from its LOAD cycle.
    bit         chkEn = 1'b0;
    bit         mBusy = 1'b0;
    bit         mB = 1'b0;
    bit         mLastB = 1'b1;
    int         mPos = 0;
    int         mLen = 1;
    logic [1:0] mSel = '0;
    logic [7:0] expMosi = '0, expRxA = '0, expRxB = '0;

    initial forever begin
        @(posedge iClock);
        if (iReset) begin
            mBusy = 1'b0; mLastB = 1'b1;
            expMosi = '0; expRxA = '0; expRxB = '0;
        end else begin
            if (mBusy) begin
                mPos++;
                if (mPos == mLen * P + GAP) mBusy = 1'b0;
            end else if (iReqA || iReqB) begin
                mB = (iReqA && iReqB) ? !mLastB : iReqB;
`ifdef EPRISC_BUS_IRQ_PRIORITY_EN
                if (iBusInterrupt && iReqA) mB = 1'b0;
`endif
                mLastB = mB;
                mBusy  = 1'b1;
                mPos   = 0;
                mLen   = mB ? int'(iLenB) : int'(iLenA);
                if (mLen == 0) mLen = 256;
                mSel   = mB ? iSelB : iSelA;
            end
            if (mBusy && mPos < mLen * P) begin
                if (mPos % P == 0) expMosi = mB ? iTxDataB : iTxDataA;
                if (mPos % P == CLKDIV + 1) begin
                    if (mB) expRxB = iBusMISO;
                    else expRxA = iBusMISO;
                end
            end
        end
    end

    bit inBurst, mDoneNow;
    int ph;
    initial forever begin
        @(negedge iClock);
        if (chkEn) begin
            inBurst  = mBusy && (mPos < mLen * P);
            mDoneNow = mBusy && (mPos == mLen * P);
            ph       = mPos % P;
            check("gntA", oGntA, inBurst && !mB);
            check("gntB", oGntB, inBurst && mB);
            check("busSelect", oBusSelect, inBurst ? mSel : 2'd0);
            check("busClock", oBusClock, inBurst && ph > CLKDIV);
            check("busMOSI", oBusMOSI, expMosi);
            check("txTakeA", oTxTakeA, inBurst && !mB && ph == 0);
            check("txTakeB", oTxTakeB, inBurst && mB && ph == 0);
            check("rxValidA", oRxValidA, inBurst && !mB && ph == CLKDIV + 1);
            check("rxValidB", oRxValidB, inBurst && mB && ph == CLKDIV + 1);
            check("rxDataA", oRxDataA, expRxA);
            check("rxDataB", oRxDataB, expRxB);
            check("doneA", oDoneA, mDoneNow && !mB);
            check("doneB", oDoneB, mDoneNow && mB);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge iClock);
    endtask

    task automatic doReset(input int n);
        iReset = 1'b1; iReqA = 1'b0; iReqB = 1'b0; iBusInterrupt = 1'b0;
        step(n);
        iReset = 1'b0;
    endtask

    // Counts take pulses until the requester's done pulse, then drops its request.
    task automatic waitDone(input bit forB, input int bound, output int takes);
        bit seen = 1'b0;
        takes = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            step(1);
            if (forB ? oTxTakeB : oTxTakeA) takes++;
            if (forB ? oDoneB : oDoneA) begin
                seen = 1'b1;
                if (forB) iReqB = 1'b0;
                else iReqA = 1'b0;
            end
        end
        check(forB ? "doneB within bound" : "doneA within bound", seen, 1);
    endtask

    typedef struct {
        int prev;   // 0 none since reset, 1 A served last, 2 B served last
        bit reqA;
        bit reqB;
        bit irq;
        bit gntA;
        bit gntB;
    } arbVec_t;

    arbVec_t    vecs[9];
    int         order[$];
    int         tcyc[$];
    logic [7:0] mosiQ[$];
    logic [7:0] t2Data[3];
    int         takes, dones, selGaps;
    bit         irqA;

    initial begin
`ifdef EPRISC_BUS_IRQ_PRIORITY_EN
        irqA = 1'b1;
`else
        irqA = 1'b0;
`endif
        vecs[0] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1, 1'b1, 1'b1, 1'b1, irqA, !irqA};
        vecs[6] = '{2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t2Data  = '{8'h11, 8'h22, 8'h33};

        step(3);
        chkEn = 1'b1;

        // Single byte from A, reset state first.
        doReset(3);
        check("reset gntA", oGntA, 0);
        check("reset select", oBusSelect, 0);
        iReqA = 1'b1; iSelA = 2'd1; iLenA = 8'd1; iTxDataA = 8'hA5; iBusMISO = 8'h3C;
        step(1);
        check("t1 gntA", oGntA, 1);
        check("t1 select", oBusSelect, 1);
        check("t1 mosi", oBusMOSI, 8'hA5);
        check("t1 takeA", oTxTakeA, 1);
        iReqA = 1'b0;
        step(3);
        check("t1 rxValidA", oRxValidA, 1);
        check("t1 rxDataA", oRxDataA, 8'h3C);
        check("t1 busClock", oBusClock, 1);
        step(2);
        check("t1 doneA", oDoneA, 1);
        check("t1 select idle", oBusSelect, 0);
        check("t1 gntA drop", oGntA, 0);
        step(2);

        // Three-byte burst from A.
        doReset(2);
        iReqA = 1'b1; iSelA = 2'd1; iLenA = 8'd3; iTxDataA = t2Data[0];
        tcyc.delete(); mosiQ.delete(); takes = 0; dones = 0; selGaps = 0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (oTxTakeA) begin
                tcyc.push_back(c);
                mosiQ.push_back(oBusMOSI);
                takes++;
                iTxDataA = (takes < 3) ? t2Data[takes] : 8'h00;
            end
            if (oDoneA) begin
                dones++;
                iReqA = 1'b0;
            end
            if (takes > 0 && dones == 0 && oBusSelect != 2'd1) selGaps++;
        end
        check("t2 take count", tcyc.size(), 3);
        check("t2 done count", dones, 1);
        check("t2 select gaps", selGaps, 0);
        for (int k = 0; k < mosiQ.size() && k < 3; k++) check("t2 mosi", mosiQ[k], t2Data[k]);
        for (int k = 1; k < tcyc.size(); k++) check("t2 take spacing", tcyc[k] - tcyc[k - 1], P);

        // Simultaneous requests held: A, B, A, B.
        doReset(2);
        iLenA = 8'd1; iLenB = 8'd1; iSelA = 2'd1; iSelB = 2'd2;
        iReqA = 1'b1; iReqB = 1'b1;
        order.delete(); tcyc.delete();
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            step(1);
            if (oTxTakeA) begin order.push_back(0); tcyc.push_back(c); end
            if (oTxTakeB) begin order.push_back(1); tcyc.push_back(c); end
        end
        iReqA = 1'b0; iReqB = 1'b0;
        check("rr burst count", order.size(), 4);
        for (int k = 0; k < order.size(); k++) check("rr order", order[k], k % 2);
        if (tcyc.size() >= 2) check("rr spacing", tcyc[1] - tcyc[0], P + GAP + 1);
        step(10);

        // Reset in the HIGH phase of byte 2 of a 4-byte B burst.
        doReset(2);
        iReqB = 1'b1; iSelB = 2'd2; iLenB = 8'd4; iTxDataB = 8'h5A; iBusMISO = 8'h77;
        step(1);
        iReqB = 1'b0;
        step(P + CLKDIV + 1);
        check("t4 in high", oBusClock, 1);
        check("t4 gntB before", oGntB, 1);
        iReset = 1'b1;
        step(1);
        iReset = 1'b0;
        check("t4 gntB", oGntB, 0);
        check("t4 select", oBusSelect, 0);
        check("t4 clock", oBusClock, 0);
        check("t4 mosi", oBusMOSI, 0);
        check("t4 rxDataB", oRxDataB, 0);
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            if (oDoneB) dones++;
        end
        check("t4 no doneB", dones, 0);
        iReqA = 1'b1; iSelA = 2'd3; iLenA = 8'd1;
        step(1);
        check("t4 gntA after reset", oGntA, 1);
        waitDone(1'b0, 20, takes);
        step(2);

        // Length 0 means 256 bytes.
        doReset(2);
        iReqB = 1'b1; iSelB = 2'd1; iLenB = 8'd0;
        waitDone(1'b1, 1400, takes);
        check("t5 takes", takes, 256);
        step(2);

        // Arbitration table.
        for (int i = 0; i < 9; i++) begin
            doReset(2);
            iLenA = 8'd1; iLenB = 8'd1; iSelA = 2'd1; iSelB = 2'd2;
            if (vecs[i].prev != 0) begin
                if (vecs[i].prev == 2) iReqB = 1'b1;
                else iReqA = 1'b1;
                waitDone(vecs[i].prev == 2, 20, takes);
                step(1);
            end
            iReqA = vecs[i].reqA; iReqB = vecs[i].reqB; iBusInterrupt = vecs[i].irq;
            step(1);
            iReqA = 1'b0; iReqB = 1'b0; iBusInterrupt = 1'b0;
            check($sformatf("vec%0d gntA", i), oGntA, vecs[i].gntA);
            check($sformatf("vec%0d gntB", i), oGntB, vecs[i].gntB);
            step(P + GAP + 1);
        end

        // Random traffic, occasional resets.
        doReset(2);
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 5) == 0) iReqA = !iReqA;
            if ($urandom_range(0, 5) == 0) iReqB = !iReqB;
            iBusInterrupt = ($urandom_range(0, 3) == 0);
            iSelA = 2'($urandom_range(0, 3));
            iSelB = 2'($urandom_range(0, 3));
            iLenA = 8'($urandom_range(1, 4));
            iLenB = 8'($urandom_range(1, 4));
            iTxDataA = 8'($urandom);
            iTxDataB = 8'($urandom);
            iBusMISO = 8'($urandom);
            iReset = ($urandom_range(0, 299) == 0);
            step(1);
        end
        iReset = 1'b0; iReqA = 1'b0; iReqB = 1'b0;
        step(20);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
